// File: rtl/tick_gen_multi.sv
// Bank of independent tick generators with per-channel period settling,
// periodic or one-shot operation and a shared phase-restart strobe.
module tick_gen_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         mode,
  input  logic [N_CH*CNT_W-1:0]   period,
  input  logic                    sync,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         stable,
  output logic                    any_tick
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       set_q, set_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] eff;
    logic             chg;

    assign p   = period[i*CNT_W +: CNT_W];
    // Zero period is treated as one so the tick spacing never collapses.
    assign eff = (p == '0) ? ONE : p;
    assign chg = (eff != per_q);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st_q   <= IDLE;
        per_q  <= '0;
        cnt_q  <= '0;
        set_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        per_q  <= per_d;
        cnt_q  <= cnt_d;
        set_q  <= set_d;
        tick_q <= tick_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      per_d  = per_q;
      cnt_d  = cnt_q;
      set_d  = set_q;
      tick_d = 1'b0;
      if (!en[i]) begin
        st_d  = IDLE;
        cnt_d = '0;
        set_d = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            st_d  = SETTLE;
            per_d = eff;
            set_d = '0;
          end
          SETTLE: begin
            if (chg) begin
              per_d = eff;
              set_d = '0;
            end else if (set_q == SET_LAST) begin
              st_d   = RUN;
              cnt_d  = '0;
              tick_d = !mode[i];
            end else begin
              set_d = set_q + 8'd1;
            end
          end
          RUN: begin
            if (chg) begin
              st_d  = SETTLE;
              per_d = eff;
              set_d = '0;
              cnt_d = '0;
            end else if (sync && !mode[i]) begin
              cnt_d  = '0;
              tick_d = 1'b1;
            end else if (cnt_q == per_q) begin
              tick_d = 1'b1;
              if (mode[i]) st_d = DONE;
              else cnt_d = '0;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          DONE: begin
            if (chg) begin
              st_d  = SETTLE;
              per_d = eff;
              set_d = '0;
              cnt_d = '0;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end

    assign tick[i]   = tick_q;
    assign stable[i] = (st_q == RUN) || (st_q == DONE);
  end

  assign any_tick = |tick;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed and randomized checks of tick_gen_multi against a
// cycle-level behavioural model of each channel.
module tb_tick_gen_multi;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic sync;
  logic [N-1:0] en, mode, tick, stable;
  logic [N*W-1:0] period;
  logic any_tick;

  always #5 clk = ~clk;

  tick_gen_multi #(.N_CH(N), .CNT_W(W), .SETTLE_CYC(S)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .mode(mode),
    .period(period),
    .sync(sync),
    .tick(tick),
    .stable(stable),
    .any_tick(any_tick)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: age<0 idle, otherwise cycles the latched period held
  int lp[N], age[N], el[N];
  bit live[N], fired[N], tk[N];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      lp[i] = 0; age[i] = -1; el[i] = 0;
      live[i] = 0; fired[i] = 0; tk[i] = 0;
    end
  endfunction

  function automatic void m_step();
    int p, e;
    if (reset) begin
      m_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      p = int'(period[i*W +: W]);
      e = (p == 0) ? 1 : p;
      if (!en[i]) begin
        age[i] = -1; live[i] = 0; fired[i] = 0; el[i] = 0; tk[i] = 0;
      end else if (age[i] < 0) begin
        lp[i] = e; age[i] = 0; tk[i] = 0;
      end else if (e != lp[i]) begin
        lp[i] = e; age[i] = 0; live[i] = 0;
        fired[i] = 0; el[i] = 0; tk[i] = 0;
      end else if (!live[i]) begin
        age[i]++;
        tk[i] = 0;
        if (age[i] == S) begin
          live[i] = 1; el[i] = 0; tk[i] = !mode[i];
        end
      end else if (fired[i]) begin
        tk[i] = 0;
      end else if (sync && !mode[i]) begin
        el[i] = 0; tk[i] = 1;
      end else if (el[i] == lp[i]) begin
        tk[i] = 1;
        if (mode[i]) fired[i] = 1;
        else el[i] = 0;
      end else begin
        el[i]++;
        tk[i] = 0;
      end
    end
  endfunction

  task automatic cmp(string tag);
    logic [N-1:0] et, es;
    for (int i = 0; i < N; i++) begin
      et[i] = tk[i];
      es[i] = live[i];
    end
    check({tag, "_tick"}, 32'(tick), 32'(et));
    check({tag, "_stable"}, 32'(stable), 32'(es));
    check({tag, "_any"}, 32'(any_tick), 32'(|et));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    m_step();
    #1;
    cmp(tag);
  endtask

  task automatic set_per(int ch, int v);
    period[ch*W +: W] = W'(v);
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0;
    en = '0; mode = '0; period = '0;
    m_reset();
    #12;
    check("rst_tick", 32'(tick), 0);
    check("rst_stable", 32'(stable), 0);
    check("rst_any", 32'(any_tick), 0);
    reset = 1'b0;

    // ch0 periodic, period 3
    en[0] = 1'b1; set_per(0, 3);
    for (int c = 1; c <= 3; c++) begin
      cycle("p3_entry");
      check("p3_st0", 32'(stable[0]), 32'(c == 3));
      check("p3_tk0", 32'(tick[0]), 32'(c == 3));
    end
    for (int c = 1; c <= 8; c++) begin
      cycle("p3_run");
      check("p3_gap", 32'(tick[0]), 32'(c % 4 == 0));
    end

    // period change 3 -> 5 while running
    cycle("p5_pre");
    set_per(0, 5);
    for (int c = 1; c <= 3; c++) begin
      cycle("p5_entry");
      check("p5_st0", 32'(stable[0]), 32'(c == 3));
      check("p5_tk0", 32'(tick[0]), 32'(c == 3));
    end
    for (int c = 1; c <= 12; c++) begin
      cycle("p5_run");
      check("p5_gap", 32'(tick[0]), 32'(c % 6 == 0));
    end

    // ch1 period 0 behaves as 1
    en[1] = 1'b1; set_per(1, 0);
    for (int c = 1; c <= 3; c++) cycle("p0_entry");
    check("p0_st1", 32'(stable[1]), 1);
    check("p0_tk1", 32'(tick[1]), 1);
    for (int c = 1; c <= 6; c++) begin
      cycle("p0_run");
      check("p0_gap", 32'(tick[1]), 32'(c % 2 == 0));
    end

    // ch2 one-shot, period 4
    en[2] = 1'b1; mode[2] = 1'b1; set_per(2, 4);
    for (int c = 1; c <= 3; c++) cycle("os_entry");
    check("os_st2", 32'(stable[2]), 1);
    check("os_notk", 32'(tick[2]), 0);
    for (int c = 1; c <= 10; c++) begin
      cycle("os_run");
      check("os_tk2", 32'(tick[2]), 32'(c == 5));
      check("os_hold", 32'(stable[2]), 1);
    end

    // ch3 period 5, different phase, then sync
    en[3] = 1'b1; set_per(3, 5);
    for (int c = 1; c <= 5; c++) cycle("sy_entry");
    sync = 1'b1;
    cycle("sy_edge");
    check("sy_tk0", 32'(tick[0]), 1);
    check("sy_tk3", 32'(tick[3]), 1);
    sync = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cycle("sy_run");
      check("sy_align", 32'({tick[3], tick[0]}), (c == 6) ? 3 : 0);
    end

    // async reset mid-run
    #2;
    reset = 1'b1;
    #1;
    check("ar_tick", 32'(tick), 0);
    check("ar_stable", 32'(stable), 0);
    check("ar_any", 32'(any_tick), 0);
    m_reset();
    cycle("ar_hold");
    #2;
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) cycle("ar_rerun");

    // en0 drop clears only on the edge
    en[0] = 1'b0;
    #1;
    check("en_pre_st0", 32'(stable[0]), 1);
    cycle("en_drop");
    check("en_st0", 32'(stable[0]), 0);
    check("en_tk0", 32'(tick[0]), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 59) == 0) mode[i] = ~mode[i];
        if ($urandom_range(0, 79) == 0) set_per(i, $urandom_range(0, 7));
      end
      sync = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        m_reset();
        cmp("rnd_rst");
        #1;
        reset = 1'b0;
      end
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
